// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [7:0] HEADER = 8'hA5;

    // Total configuration width T for a LUT array.
    function automatic int conf_width(input int inputs, input int luts);
        return luts * (1 << inputs);
    endfunction

    // Payload byte count N = ceil(T/8).
    function automatic int payload_bytes(input int inputs, input int luts);
        return (conf_width(inputs, luts) + 7) / 8;
    endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Byte-stream configuration bus between a source and the loader.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the source
// holds in_data stable while in_valid is high, and in_ready never depends on in_valid.
interface lut_config_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/lut_config_loader_core.sv
// Packet FSM, shadow register and XOR accumulator; commits a verified packet atomically.
module lut_config_loader_core
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS = 2,
    parameter int LUTS   = 4,
    localparam int T     = conf_width(INPUTS, LUTS)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    lut_config_loader_if.slave   bus,
    input  logic                 abort,
    output logic [T-1:0]         conf,
    output logic                 conf_valid,
    output logic                 busy,
    output logic                 error,
    output state_e               state_dbg
);

    localparam int N  = payload_bytes(INPUTS, LUTS);
    localparam int CW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [T-1:0]    shadow_q, shadow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      xor_q, xor_d;
    logic            match_q, match_d;
    logic [T-1:0]    conf_q, conf_d;
    logic            conf_valid_q, conf_valid_d;
    logic            error_q, error_d;
    logic            xfer;

    assign bus.in_ready = (state_q != COMMIT);
    // abort suppresses the transfer on its own edge
    assign xfer         = bus.in_valid && bus.in_ready && !abort;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        xor_d        = xor_q;
        match_d      = match_q;
        conf_d       = conf_q;
        conf_valid_d = conf_valid_q;
        error_d      = error_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer && bus.in_data == HEADER) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        // bits of the last byte beyond T are dropped here but still XORed
                        for (int b = 0; b < T; b++) begin
                            if (cnt_q == CW'(b / 8)) shadow_d[b] = bus.in_data[3'(b % 8)];
                        end
                        xor_d = xor_q ^ bus.in_data;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        match_d = (bus.in_data == xor_q);
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                    if (match_q) begin
                        conf_d       = shadow_q;
                        conf_valid_d = 1'b1;
                        error_d      = 1'b0;
                    end else begin
                        error_d      = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            xor_q        <= '0;
            match_q      <= 1'b0;
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            xor_q        <= xor_d;
            match_q      <= match_d;
            conf_q       <= conf_d;
            conf_valid_q <= conf_valid_d;
            error_q      <= error_d;
        end
    end

    assign conf       = conf_q;
    assign conf_valid = conf_valid_q;
    assign error      = error_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: rtl/lut_config_loader.sv
// Top level: one configuration loader plus per-LUT slicing of the committed word.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS = 2,
    parameter int LUTS   = 4,
    localparam int T     = conf_width(INPUTS, LUTS),
    localparam int LW    = 1 << INPUTS
) (
    input  logic                     clock,
    input  logic                     rst_n,
    lut_config_loader_if.slave       bus,
    input  logic                     abort,
    output logic [T-1:0]             conf,
    output logic [LUTS-1:0][LW-1:0]  lut_conf,
    output logic                     conf_valid,
    output logic                     busy,
    output logic                     error,
    output state_e                   state_dbg
);

    lut_config_loader_core #(
        .INPUTS (INPUTS),
        .LUTS   (LUTS)
    ) u_core (
        .clock      (clock),
        .rst_n      (rst_n),
        .bus        (bus),
        .abort      (abort),
        .conf       (conf),
        .conf_valid (conf_valid),
        .busy       (busy),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // LUT k reads its truth table from conf[k*LW +: LW]
    for (genvar k = 0; k < LUTS; k++) begin : g_lut
        assign lut_conf[k] = conf[k*LW +: LW];
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Randomized scoreboard bench for lut_config_loader with a packet-level reference model.
module tb_lut_config_loader;
    import lut_cfg_pkg::*;

    localparam int INPUTS = 2;
    localparam int LUTS   = 4;
    localparam int T      = conf_width(INPUTS, LUTS);
    localparam int N      = payload_bytes(INPUTS, LUTS);
    localparam int LW     = 1 << INPUTS;
    localparam int W      = T + 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [T-1:0]            conf;
    logic [LUTS-1:0][LW-1:0] lut_conf;
    logic                    conf_valid, busy, error;
    state_e                  state_dbg;

    lut_config_loader_if bus ();

    lut_config_loader #(.INPUTS(INPUTS), .LUTS(LUTS)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .bus        (bus),
        .abort      (abort),
        .conf       (conf),
        .lut_conf   (lut_conf),
        .conf_valid (conf_valid),
        .busy       (busy),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  exp_q[$];
    logic [T-1:0]  last_conf = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    logic [T-1:0] m_conf = '0;
    logic         m_cv   = 1'b0;
    logic         m_err  = 1'b0;
    bit           m_in_pkt = 0;
    logic [7:0]   m_pkt[$];

    function automatic void model_feed(input logic [7:0] b);
        logic [7:0] x;
        int         idx;
        if (!m_in_pkt) begin
            if (b == 8'hA5) begin
                m_in_pkt = 1;
                m_pkt.delete();
            end
        end else begin
            m_pkt.push_back(b);
            if (m_pkt.size() == N + 1) begin
                x = 8'h00;
                for (int i = 0; i < N; i++) x ^= m_pkt[i];
                if (x == m_pkt[N]) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < 8; j++) begin
                            idx = 8 * i + j;
                            if (idx < T) m_conf[idx] = m_pkt[i][j];
                        end
                    m_cv  = 1'b1;
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                exp_q.push_back({m_err, m_cv, m_conf});
                m_in_pkt = 0;
            end
        end
    endfunction

    function automatic void model_reset();
        m_conf   = '0;
        m_cv     = 1'b0;
        m_err    = 1'b0;
        m_in_pkt = 0;
        m_pkt.delete();
        exp_q.delete();
        last_conf = '0;
    endfunction

    // ---------------- driver tasks ----------------
    // All driver tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, output int xcyc);
        int guard = 0;
        bit acc   = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clock);
            acc = bus.in_ready && !abort;
            @(posedge clock);
            #1;
            if (acc) break;
            guard++;
            if (guard > 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: byte %0h not accepted, expected acceptance within 20 cycles", b);
                break;
            end
        end
        xcyc = cyc;
        bus.in_valid = 1'b0;
        if (acc) model_feed(b);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(0, 255));
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input int gap_min, input int gap_max);
        int t;
        foreach (seq[i]) begin
            if (gap_max > 0) idle($urandom_range(gap_min, gap_max));
            send_byte(seq[i], t);
        end
    endtask

    task automatic do_abort();
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom_range(0, 255));
        @(posedge clock);
        #1;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        m_in_pkt     = 0;
    endtask

    task automatic check_state(input string tag, input logic [T-1:0] c, input logic cv, input logic er);
        idle(3);
        @(negedge clock);
        check({tag, "_conf"}, conf, c);
        check({tag, "_conf_valid"}, conf_valid, cv);
        check({tag, "_error"}, error, er);
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor: pops on every commit cycle ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (rst_n && !bus.in_ready) begin
                check("busy_in_commit", busy, 1);
                check("conf_stable_in_commit", conf, last_conf);
                @(negedge clock);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: got a commit cycle, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_conf", conf, e[T-1:0]);
                    check("sb_lut_conf", lut_conf, e[T-1:0]);
                    check("sb_conf_valid", conf_valid, e[T]);
                    check("sb_error", error, e[T+1]);
                    last_conf = e[T-1:0];
                end
                check("in_ready_after_commit", bus.in_ready, 1);
                check("busy_after_commit", busy, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, t2, t3;
        logic [7:0] pay[$];
        logic [7:0] x;
        int r, k;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_conf", conf, 0);
        check("rst_conf_valid", conf_valid, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // back-to-back good packet
        send_byte(8'hA5, t0);
        send_byte(8'h3C, t1);
        send_byte(8'h96, t2);
        send_byte(8'hAA, t3);
        check("b2b_throughput", t3 - t0, N + 1);
        check_state("good1", 16'h963C, 1, 0);

        // bad checksum, then a good packet clears error
        send_seq('{8'hA5, 8'h01, 8'h02, 8'hFF}, 0, 0);
        check_state("badsum", 16'h963C, 1, 1);
        send_seq('{8'hA5, 8'h44, 8'h55, 8'h11}, 0, 0);
        check_state("clear_err", 16'h5544, 1, 0);

        // junk before header; header value inside payload is data
        send_seq('{8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h11, 8'h22, 8'h33}, 0, 0);
        check_state("junk", 16'h2211, 1, 0);
        send_seq('{8'hA5, 8'hA5, 8'h00, 8'hA5}, 0, 0);
        check_state("hdr_as_data", 16'h00A5, 1, 0);

        // abort mid-packet
        send_seq('{8'hA5, 8'h77}, 0, 0);
        do_abort();
        @(negedge clock);
        check("abort_busy", busy, 0);
        check("abort_conf", conf, 16'h00A5);
        @(posedge clock);
        #1;
        send_seq('{8'hA5, 8'h10, 8'h20, 8'h30}, 0, 0);
        check_state("after_abort", 16'h2010, 1, 0);

        // gaps between every byte; busy rises after the header
        send_byte(8'hA5, t0);
        @(negedge clock);
        check("busy_after_hdr", busy, 1);
        @(posedge clock);
        #1;
        send_seq('{8'hC3, 8'h5A, 8'h99}, 1, 3);
        check_state("gaps", 16'h5AC3, 1, 0);

        // asynchronous reset mid-LOAD
        send_seq('{8'hA5, 8'h66}, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_conf", conf, 0);
        check("arst_conf_valid", conf_valid, 0);
        check("arst_error", error, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        model_reset();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_seq('{8'hA5, 8'h12, 8'h34, 8'h26}, 0, 0);
        check_state("post_rst", 16'h3412, 1, 0);

        // randomized packets against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            pay.delete();
            repeat ($urandom_range(0, 2)) begin
                x = 8'($urandom_range(0, 255));
                if (x == 8'hA5) x = 8'h5A;
                pay.push_back(x);
            end
            pay.push_back(8'hA5);
            x = 8'h00;
            for (int i = 0; i < N; i++) begin
                pay.push_back(8'($urandom_range(0, 255)));
                x ^= pay[pay.size() - 1];
            end
            if (r == 0) begin
                k = $urandom_range(0, N);
                for (int i = 0; i < N - k; i++) void'(pay.pop_back());
                send_seq(pay, 0, ($urandom_range(0, 1) == 1) ? 2 : 0);
                do_abort();
            end else begin
                if (r < 3) x ^= 8'($urandom_range(1, 255));
                pay.push_back(x);
                send_seq(pay, 0, ($urandom_range(0, 1) == 1) ? 2 : 0);
            end
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lut_config_loader.md
# lut_config_loader

Byte-stream configuration loader that sits directly upstream of the LUT array and drives its `conf` inputs. It accepts framed configuration packets on an 8-bit valid/ready bus, assembles them into a shadow register and verifies an XOR checksum. Only a verified packet updates the LUT configuration, as one atomic word. It reports busy, valid and error status to the top level.

## Interface
- `INPUTS`, 2, LUT input count; each LUT needs `2**INPUTS` config bits.
- `LUTS`, 4, number of LUTs fed; total config width `T = LUTS * 2**INPUTS`.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  8  configuration byte stream.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `abort`  in  1  synchronous cancel of any packet in progress.
- `conf`  out  T  committed configuration; LUT k uses bits `[k*2**INPUTS +: 2**INPUTS]`.
- `conf_valid`  out  1  `conf` holds at least one verified packet.
- `busy`  out  1  a packet is in progress (state is not IDLE).
- `error`  out  1  the most recent packet failed its checksum; sticky until the next commit attempt.

## Operation
- Packet format: header `8'hA5`, then `N = ceil(T/8)` payload bytes, then one checksum byte.
- The checksum byte equals the XOR of all payload bytes.
- A byte transfers on an edge where `in_valid && in_ready`.
- Payload byte i (0-based) loads shadow bits `[8i +: 8]`. Bits at index T and above in the last byte are discarded, but they still enter the checksum.
- States are IDLE, LOAD, CHECK and COMMIT.
  - IDLE: a transferred byte equal to `8'hA5` moves to LOAD and clears the byte counter and running XOR. Any other byte is consumed and ignored.
  - LOAD: each transferred byte updates the shadow register and the XOR, and increments the counter. When byte N-1 transfers, move to CHECK.
  - CHECK: the transferred byte is compared to the running XOR and the match flag is latched. Move to COMMIT.
  - COMMIT: lasts exactly one cycle with `in_ready=0`.
    - On a match: `conf <= shadow`, `conf_valid <= 1`, `error <= 0`.
    - On a mismatch: `error <= 1`; `conf` and `conf_valid` are unchanged.
    - Either way, return to IDLE.
- `in_ready` is 1 in IDLE, LOAD and CHECK, and 0 in COMMIT.
- `abort` is sampled each edge. From any state it returns to IDLE, and no byte transfers on that edge. `conf`, `conf_valid` and `error` are untouched. `abort` in COMMIT cancels the commit.
- A header byte received in LOAD or CHECK is treated as data or checksum; it does not resync the packet.
- The counter is `$clog2(N+1)` bits wide. It never wraps within a packet, because LOAD exits at N-1.

## Timing
- Reset values: state IDLE, `conf=0`, `conf_valid=0`, `error=0`, `busy=0`, `in_ready=1`. Shadow, counter and XOR are all 0.
- Reset asserted mid-packet discards the packet immediately, without waiting for a clock edge.
- Throughput: one byte per cycle. A full packet takes N+2 transfer cycles plus 1 COMMIT cycle.
- Latency: if the checksum byte transfers at edge k, then `conf`, `conf_valid` and `error` change at edge k+1. `in_ready` is 1 again from edge k+1.
- `busy` is 1 from the edge after the header transfers through the COMMIT cycle. It is 0 from edge k+1.
- `conf` is registered and never changes except at a COMMIT edge with a matching checksum.

## Structure
- Package `lut_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, CHECK, COMMIT);
  - `localparam HEADER = 8'hA5`;
  - helper functions computing T and N from INPUTS and LUTS.
- There is no sub-module: the FSM, shadow register and XOR accumulator live in one module.
- The top level instantiates one loader and slices `conf` per LUT.

## Test plan
- Defaults, bytes `A5 3C 96 AA` back-to-back with `in_valid=1` -> `conf=16'h963C`, `conf_valid=1`, `error=0` one edge after `AA`. `in_ready=0` for exactly that COMMIT cycle.
- Bad checksum, bytes `A5 01 02 FF` after a good load -> `error=1`, `conf` still `16'h963C`, `conf_valid=1`. A following good packet clears `error`.
- Junk before header, bytes `00 5A FF A5 11 22 33` -> junk ignored, `conf=16'h2211`.
- Abort: `abort` after `A5 77` -> `busy=0`. Then `A5 10 20 30` -> `conf=16'h2010`. The 77 byte has no effect.
- Gaps in `in_valid` between every byte of a good packet -> same result as back-to-back. Bytes are accepted only when valid.
- `rst_n` low mid-LOAD -> all outputs return to reset values immediately. The next packet loads normally.
